// File: rtl/mem_pkg.sv
// Shared access-size encodings, FSM states and lane helpers for the LSU data memory
// and the pipeline LSU that drives it.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(size_e sz);
    logic [2:0] m;
    unique case (sz)
      SZ_B: m = 3'b000;
      SZ_H: m = 3'b001;
      SZ_W: m = 3'b011;
      SZ_D: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_mask(size_e sz, logic [2:0] off);
    logic [7:0] m;
    unique case (sz)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: moves the addressed byte lanes down to bit 0 and
// sign- or zero-extends the result to 64 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] i_dword,
  input  logic [2:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;
  logic        w_sign;

  assign w_shifted = i_dword >> {i_offset, 3'b000};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_sign = 1'b0;
    o_data = w_shifted;
    unique case (i_size)
      SZ_B: begin
        w_sign = ~i_unsigned & w_shifted[7];
        o_data = {{56{w_sign}}, w_shifted[7:0]};
      end
      SZ_H: begin
        w_sign = ~i_unsigned & w_shifted[15];
        o_data = {{48{w_sign}}, w_shifted[15:0]};
      end
      SZ_W: begin
        w_sign = ~i_unsigned & w_shifted[31];
        o_data = {{32{w_sign}}, w_shifted[31:0]};
      end
      SZ_D: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Doubleword-organised LSU data memory: single-cycle load/store with byte lanes,
// alignment/range faults, latency-1 responses and an optional post-reset zeroing walk.
module lsu_data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 64,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int     IDX_W     = $clog2(DEPTH);
  localparam state_e RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

  logic [63:0] r_mem [DEPTH];

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_init_done, w_init_done_nxt;

  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic [63:0]       r_rsp_rdata;

  size_e             w_size;
  logic [2:0]        w_offset;
  logic [IDX_W-1:0]  w_index;
  logic              w_oor;
  logic              w_misalign;
  logic              w_fault;
  logic              w_accept;
  logic              w_wr_en;
  logic [7:0]        w_lanes;
  logic [63:0]       w_wdata_sh;
  logic [63:0]       w_rd_dword;
  logic [63:0]       w_load_data;

  // Request decode
  assign w_size     = size_e'(req_size);
  assign w_offset   = req_addr[2:0];
  assign w_index    = req_addr[IDX_W+2:3];
  assign w_oor      = |req_addr[ADDR_W-1:IDX_W+3];
  assign w_misalign = |(w_offset & align_mask(w_size));
  assign w_fault    = w_oor | w_misalign;

  assign req_ready  = (r_state == ST_READY);
  assign w_accept   = req_valid & req_ready;
  assign w_wr_en    = w_accept & req_we & ~w_fault;
  assign w_lanes    = lane_mask(w_size, w_offset);
  assign w_wdata_sh = req_wdata << {w_offset, 3'b000};

  // Asynchronous read of the current array contents: a store retired at the previous
  // edge is already visible here, so a following load never sees stale data.
  assign w_rd_dword = r_mem[w_index];

  load_align u_load_align (
    .i_dword    (w_rd_dword),
    .i_offset   (w_offset),
    .i_size     (w_size),
    .i_unsigned (req_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_init_done_nxt = r_init_done;
    unique case (r_state)
      ST_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == IDX_W'(DEPTH - 1)) begin
          w_state_nxt     = ST_READY;
          w_init_done_nxt = 1'b1;
        end
      end
      ST_READY: w_init_done_nxt = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_idx       <= '0;
      r_init_done <= !INIT_CLEAR;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_fault <= w_accept & w_fault;
      r_rsp_rdata <= (w_accept & ~w_fault & ~req_we) ? w_load_data : '0;
    end
  end

  // NOTE: the array deliberately has no reset; zeroing happens only through the CLEAR walk.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (w_lanes[b]) r_mem[w_index][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_fault;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: table-driven vectors, a byte-level reference
// model for random traffic, and hand-written reset/clear-walk sequences.
module tb_lsu_data_mem;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;
  logic        init_done;

  lsu_data_mem #(.DEPTH(256), .ADDR_W(64), .INIT_CLEAR(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        fault;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic        fault;
    logic [63:0] rdata;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  mdl [0:2047];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic f, input logic [63:0] rd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
    v.fault = f; v.rdata = rd;
    return v;
  endfunction

  // Byte-addressed reference: applies stores, returns extended load data and fault.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic f, output logic [63:0] rd);
    int          nb;
    int          base;
    logic [63:0] val;
    nb   = 1 << sz;
    base = int'(addr[10:0]);
    f    = (addr[63:11] != 0) || ((int'(addr[2:0]) % nb) != 0);
    rd   = '0;
    if (!f) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mdl[base + i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = mdl[base + i];
        if (sz != 2'd3 && !uns && val[8*nb - 1]) begin
          for (int i = 8*nb; i < 64; i++) val[i] = 1'b1;
        end
        rd = val;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2048; i++) mdl[i] = 8'h00;
  endtask

  // Called at a negedge; drives one request and leaves it on the bus for the next edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic ef, input logic [63:0] er, input int id);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    check($sformatf("req_ready#%0d", id), req_ready, 1);
    e.due = cyc + 1; e.id = id; e.fault = ef; e.rdata = er;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (!init_done && cnt < 1000) begin
      check({name, "_ready_low"}, req_ready, 0);
      @(negedge clk);
      cnt++;
    end
    check({name, "_cycles"}, cnt, 256);
    check({name, "_ready"}, req_ready, 1);
  endtask

  // Response monitor: every cycle out of reset either an expected response is due or none may appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        mon_e = sb_q.pop_front();
        check($sformatf("rsp_valid#%0d", mon_e.id), rsp_valid, 1);
        check($sformatf("rsp_fault#%0d", mon_e.id), rsp_fault, mon_e.fault);
        check($sformatf("rsp_rdata#%0d", mon_e.id), rsp_rdata, mon_e.rdata);
      end else begin
        check("rsp_idle", rsp_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        f;
    logic [63:0] rd;
    logic [1:0]  sz;
    logic [2:0]  am;
    logic [63:0] a;
    logic [63:0] wd;
    logic        we;
    logic        uns;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    clear_model();

    tbl.push_back(mk(0, 2'd3, 0, 64'h40, 0, 0, 64'h0));
    tbl.push_back(mk(1, 2'd3, 0, 64'h10, 64'h8877665544332211, 0, 64'h0));
    tbl.push_back(mk(0, 2'd0, 0, 64'h17, 0, 0, 64'hFFFFFFFFFFFFFF88));
    tbl.push_back(mk(0, 2'd0, 1, 64'h17, 0, 0, 64'h88));
    tbl.push_back(mk(0, 2'd1, 1, 64'h12, 0, 0, 64'h4433));
    tbl.push_back(mk(0, 2'd1, 0, 64'h16, 0, 0, 64'hFFFFFFFFFFFF8877));
    tbl.push_back(mk(0, 2'd2, 0, 64'h14, 0, 0, 64'hFFFFFFFF88776655));
    tbl.push_back(mk(0, 2'd2, 1, 64'h10, 0, 0, 64'h44332211));
    tbl.push_back(mk(1, 2'd3, 0, 64'h08, 64'h0123456789ABCDEF, 0, 64'h0));
    tbl.push_back(mk(1, 2'd1, 0, 64'h0A, 64'hFFFFFFFFFFFFBEEF, 0, 64'h0));
    tbl.push_back(mk(0, 2'd3, 0, 64'h08, 0, 0, 64'h01234567BEEFCDEF));
    tbl.push_back(mk(0, 2'd2, 0, 64'h06, 0, 1, 64'h0));
    tbl.push_back(mk(1, 2'd3, 0, 64'h800, 64'hDEAD, 1, 64'h0));
    tbl.push_back(mk(0, 2'd3, 0, 64'h00, 0, 0, 64'h0));
    tbl.push_back(mk(0, 2'd1, 0, 64'h0B, 0, 1, 64'h0));
    tbl.push_back(mk(1, 2'd0, 0, 64'h11, 64'h12345A, 0, 64'h0));
    tbl.push_back(mk(0, 2'd3, 1, 64'h10, 0, 0, 64'h8877665544335A11));
    tbl.push_back(mk(0, 2'd0, 1, 64'h11, 0, 0, 64'h5A));
    tbl.push_back(mk(1, 2'd2, 0, 64'h1C, 64'h80000000, 0, 64'h0));
    tbl.push_back(mk(0, 2'd2, 0, 64'h1C, 0, 0, 64'hFFFFFFFF80000000));
    tbl.push_back(mk(0, 2'd2, 1, 64'h1C, 0, 0, 64'h80000000));
    tbl.push_back(mk(0, 2'd3, 0, 64'h18, 0, 0, 64'h8000000000000000));
    tbl.push_back(mk(0, 2'd3, 0, 64'h7F8, 0, 0, 64'h0));
    tbl.push_back(mk(0, 2'd0, 0, 64'h7FF, 0, 0, 64'h0));
    tbl.push_back(mk(0, 2'd3, 0, 64'h7FC, 0, 1, 64'h0));
    tbl.push_back(mk(0, 2'd0, 0, 64'hFFFFFFFF00000001, 0, 1, 64'h0));

    // Reset values while rst_n is held low
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init1");

    // Table vectors, back to back with no bubbles
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, f, rd);
      issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
            tbl[i].fault, tbl[i].rdata, i);
    end
    idle();

    // Random traffic against the reference model, concentrated in the low 256 bytes
    for (int i = 0; i < 120; i++) begin
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      a   = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 0) a[10:8] = 3'b000;
      if ($urandom_range(0, 9) == 0) a[$urandom_range(11, 63)] = 1'b1;
      am = 3'((1 << sz) - 1);
      if ($urandom_range(0, 4) != 0) a[2:0] = a[2:0] & ~am;
      model(we, sz, uns, a, wd, f, rd);
      issue(we, sz, uns, a, wd, f, rd, 100 + i);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();

    // Reset asserted while a response is on the bus
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h10; req_wdata = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midrsp_valid_before", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrsp_valid_after", rsp_valid, 0);
    check("midrsp_rdata_after", rsp_rdata, 0);
    check("midrsp_init_done", init_done, 0);
    check("midrsp_req_ready", req_ready, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted partway through the clear walk (idx = 100)
    repeat (100) @(posedge clk);
    #2;
    check("midwalk_ready_before", req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midwalk_rsp_valid", rsp_valid, 0);
    check("midwalk_init_done", init_done, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");

    // Walk must have zeroed entries written before the resets
    for (int i = 0; i < 4; i++) begin
      a = 64'(8 * i + 8);
      model(1'b0, 2'd3, 1'b0, a, '0, f, rd);
      issue(1'b0, 2'd3, 1'b0, a, '0, f, rd, 300 + i);
    end
    issue(1'b0, 2'd3, 1'b0, 64'h7F8, '0, 1'b0, 64'h0, 310);
    idle();
    idle();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
